// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : receiver state encoding, frame-length helper and shared defaults
// Rev 1.0
// ============================================================================
package uart_pkg;

   localparam int DEF_OVERSAMPLE = 16;
   localparam int DEF_DATA_BITS  = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START_CHK = 2'd1,
      FRAME     = 2'd2
   } rx_state_t;

   function automatic int nbits(input int data_bits, input int parity_en, input int stop_bits);
      return data_bits + parity_en + stop_bits;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_start_sync_if.sv
`default_nettype none
// ============================================================================
// uart_rx_start_sync_if : serial input, tick enable and bit-timing outputs
// Rev 1.0
// ============================================================================
interface uart_rx_start_sync_if;

   logic       rxin;
   logic       tick;
   logic       startbit;
   logic       bit_strobe;
   logic       bit_val;
   logic [3:0] bit_idx;
   logic       busy;
   logic       frame_done;
   logic       frame_err;
   logic       false_start;

   modport master (
      output rxin, tick,
      input  startbit, bit_strobe, bit_val, bit_idx, busy, frame_done, frame_err, false_start
   );

   modport slave (
      input  rxin, tick,
      output startbit, bit_strobe, bit_val, bit_idx, busy, frame_done, frame_err, false_start
   );

endinterface
`default_nettype wire

// File: rtl/uart_sync_bit.sv
`default_nettype none
// ============================================================================
// uart_sync_bit : multi-flop synchroniser for one asynchronous bit, resets to 1
// Rev 1.0
// ============================================================================
module uart_sync_bit #(
   parameter int STAGES = 2
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic d,
   output logic      q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk) begin
      if (rst) chain <= '1;
      else     chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_start_sync.sv
`default_nettype none
// ============================================================================
// uart_rx_start_sync : start-bit qualifier and mid-bit strobe generator
// Rev 1.0
// ============================================================================
module uart_rx_start_sync
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
   parameter int START_MIN   = DEF_OVERSAMPLE / 2,
   parameter int DATA_BITS   = DEF_DATA_BITS,
   parameter int PARITY_EN   = 1,
   parameter int STOP_BITS   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  wire logic           clk,
   input  wire logic           rst,
   uart_rx_start_sync_if.slave bus
);

   localparam int NBITS = nbits(DATA_BITS, PARITY_EN, STOP_BITS);
   localparam int TW    = $clog2(OVERSAMPLE);
   localparam int LW    = $clog2(START_MIN + 1);

   localparam logic [TW-1:0] TICK_LAST   = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] TICK_FIRST  = TW'(START_MIN);
   localparam logic [TW-1:0] TICK_STROBE = TW'((START_MIN + OVERSAMPLE - 1) % OVERSAMPLE);
   localparam logic [LW-1:0] LOW_MIN     = LW'(START_MIN);
   localparam logic [3:0]    IDX_STOP    = 4'(DATA_BITS + PARITY_EN);
   localparam logic [3:0]    IDX_LAST    = 4'(NBITS - 1);

   logic          line;
   rx_state_t     state_q, state_d;
   logic          armed_q, armed_d;
   logic [LW-1:0] lowcnt_q, lowcnt_d;
   logic [TW-1:0] tickcnt_q, tickcnt_d;
   logic [3:0]    idx_q, idx_d;
   logic          err_q, err_d;
   logic          go, stop_bad;

   logic          startbit_q, startbit_d;
   logic          strobe_q, strobe_d;
   logic          val_q, val_d;
   logic [3:0]    bidx_q, bidx_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          ferr_q, ferr_d;
   logic          false_q, false_d;

   uart_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.rxin),
      .q   (line)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         armed_q    <= 1'b0;
         lowcnt_q   <= '0;
         tickcnt_q  <= '0;
         idx_q      <= '0;
         err_q      <= 1'b0;
         startbit_q <= 1'b0;
         strobe_q   <= 1'b0;
         val_q      <= 1'b0;
         bidx_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ferr_q     <= 1'b0;
         false_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         armed_q    <= armed_d;
         lowcnt_q   <= lowcnt_d;
         tickcnt_q  <= tickcnt_d;
         idx_q      <= idx_d;
         err_q      <= err_d;
         startbit_q <= startbit_d;
         strobe_q   <= strobe_d;
         val_q      <= val_d;
         bidx_q     <= bidx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ferr_q     <= ferr_d;
         false_q    <= false_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      armed_d    = armed_q;
      lowcnt_d   = lowcnt_q;
      tickcnt_d  = tickcnt_q;
      idx_d      = idx_q;
      err_d      = err_q;
      go         = 1'b0;
      stop_bad   = 1'b0;
      startbit_d = 1'b0;
      strobe_d   = 1'b0;
      val_d      = val_q;
      bidx_d     = bidx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      ferr_d     = 1'b0;
      false_d    = 1'b0;

      if (bus.tick) begin
         if (line) armed_d = 1'b1;
         case (state_q)
            IDLE: begin
               if (!line && armed_q) begin
                  lowcnt_d = LW'(1);
                  if (START_MIN == 1) go = 1'b1;
                  else                state_d = START_CHK;
               end
            end
            START_CHK: begin
               if (line) begin
                  false_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  lowcnt_d = lowcnt_q + 1'b1;
                  if (lowcnt_d == LOW_MIN) go = 1'b1;
               end
            end
            FRAME: begin
               // Free-running phase counter; the strobe lands one bit period after the confirm point.
               tickcnt_d = (tickcnt_q == TICK_LAST) ? '0 : tickcnt_q + 1'b1;
               if (tickcnt_q == TICK_STROBE) begin
                  strobe_d = 1'b1;
                  val_d    = line;
                  bidx_d   = idx_q;
                  stop_bad = (idx_q >= IDX_STOP) && !line;
                  if (idx_q == IDX_LAST) begin
                     done_d  = 1'b1;
                     ferr_d  = err_q | stop_bad;
                     busy_d  = 1'b0;
                     state_d = IDLE;
                     armed_d = !(err_q | stop_bad);
                     idx_d   = '0;
                     err_d   = 1'b0;
                  end else begin
                     idx_d = idx_q + 1'b1;
                     err_d = err_q | stop_bad;
                  end
               end
            end
            default: state_d = IDLE;
         endcase

         if (go) begin
            startbit_d = 1'b1;
            busy_d     = 1'b1;
            state_d    = FRAME;
            tickcnt_d  = TICK_FIRST;
            idx_d      = '0;
            err_d      = 1'b0;
         end
      end
   end

   assign bus.startbit    = startbit_q;
   assign bus.bit_strobe  = strobe_q;
   assign bus.bit_val     = val_q;
   assign bus.bit_idx     = bidx_q;
   assign bus.busy        = busy_q;
   assign bus.frame_done  = done_q;
   assign bus.frame_err   = ferr_q;
   assign bus.false_start = false_q;

endmodule
`default_nettype wire
